// File: rtl/fifo_word_packer_pkg.sv
// ============================================================================
//  Module      : fifo_word_packer_pkg
//  Description : Shared types and helpers for the FIFO word packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_word_packer_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Width needed to hold a word count in the range 0..ratio.
    function automatic int count_w(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage : fifo_word_packer_pkg

`default_nettype wire

// File: rtl/fifo_word_packer.sv
// ============================================================================
//  Module      : fifo_word_packer
//  Description : Pops RATIO words from a show-ahead FIFO and presents them as
//                one packed word on a valid/ready interface; flush emits a
//                partial word. Optional macro FIFO_WORD_PACKER_ZERO_FILL_EN
//                zeroes the unused slots of partial words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_word_packer
    import fifo_word_packer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RATIO = 4,
    parameter int CW    = count_w(RATIO)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   empty,
    input  logic [WIDTH-1:0]       read_data,
    output logic                   pop,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*RATIO-1:0] out_data,
    output logic [CW-1:0]          out_count
);

    localparam logic [CW-1:0] C_LAST_SLOT = CW'(RATIO - 1);
    localparam logic [CW-1:0] C_FULL_CNT  = CW'(RATIO);

    state_t                 state_q, state_d;
    logic [CW-1:0]          fill_q, fill_d;
    logic [CW-1:0]          count_q, count_d;
    logic [WIDTH*RATIO-1:0] data_q, data_d;

    logic                   w_in_fill;

    assign w_in_fill = (state_q == FILL);

    // Pop is gated by rst so the FIFO is never drained while held in reset.
    assign pop       = ~rst & ~empty & (w_in_fill | out_ready);

    assign out_valid = (state_q == HOLD);
    assign out_data  = data_q;
    assign out_count = count_q;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        count_d = count_q;
        data_d  = data_q;

        case (state_q)
            FILL: begin
                for (int i = 0; i < RATIO; i++) begin
                    if (pop && (fill_q == CW'(i))) begin
                        data_d[i*WIDTH +: WIDTH] = read_data;
                    end
                end
                if (pop) begin
                    fill_d = fill_q + CW'(1);
                end
                if (pop && (fill_q == C_LAST_SLOT)) begin
                    state_d = HOLD;
                    count_d = C_FULL_CNT;
                    fill_d  = '0;
                end else if (flush && ((fill_q != '0) || pop)) begin
                    state_d = HOLD;
                    count_d = fill_q + CW'(pop);
                    fill_d  = '0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = FILL;
                    count_d = '0;
                    fill_d  = '0;
`ifdef FIFO_WORD_PACKER_ZERO_FILL_EN
                    // Slots are only ever written in order from 0, so clearing
                    // here guarantees zeros above any later partial word.
                    data_d  = '0;
`endif
                    if (pop) begin
                        data_d[WIDTH-1:0] = read_data;
                        fill_d            = CW'(1);
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            fill_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

endmodule : fifo_word_packer

`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
// ============================================================================
//  Module      : tb_fifo_word_packer
//  Description : Directed bench for fifo_word_packer (WIDTH=8, RATIO=4) with a
//                queue-modelled show-ahead FIFO and an output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_word_packer;

    logic        clk;
    logic        rst;
    logic        empty;
    logic [7:0]  read_data;
    logic        pop;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  fifo_q[$];
    logic [31:0] exp_data_q[$];
    logic [2:0]  exp_cnt_q[$];

    logic        last_pop;
    logic        last_valid;
    logic [31:0] last_data;
    int          pop_cnt = 0;

    fifo_word_packer #(.WIDTH(8), .RATIO(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .read_data (read_data),
        .pop       (pop),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(first + 8'(i));
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [2:0] c);
        exp_data_q.push_back(d);
        exp_cnt_q.push_back(c);
    endtask

    task automatic check_out();
        logic [31:0] ed;
        logic [2:0]  ec;
        logic [31:0] m;
        if (exp_data_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_out observed=%0h expected=none", out_data);
            return;
        end
        ed = exp_data_q.pop_front();
        ec = exp_cnt_q.pop_front();
        m  = '0;
        for (int i = 0; i < 4; i++) if (i < int'(ec)) m[i*8 +: 8] = 8'hff;
`ifdef FIFO_WORD_PACKER_ZERO_FILL_EN
        m = '1;
`endif
        chk("out_count", 32'(out_count), 32'(ec));
        chk("out_data", out_data & m, ed & m);
    endtask

    // One clock cycle: drive at negedge, observe after settle, model FIFO pop.
    task automatic step(input logic fl, input logic rdy);
        @(negedge clk);
        flush     = fl;
        out_ready = rdy;
        empty     = (fifo_q.size() == 0);
        read_data = empty ? 8'h00 : fifo_q[0];
        #1;
        last_pop   = pop;
        last_valid = out_valid;
        last_data  = out_data;
        if (out_valid && out_ready) check_out();
        if (pop) begin
            if (fifo_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL pop_while_empty observed=1 expected=0");
            end else begin
                void'(fifo_q.pop_front());
            end
            pop_cnt++;
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_data_q.size() > 0; i++) step(1'b0, 1'b1);
        chk("drain_timeout", 32'(exp_data_q.size()), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        empty     = 1'b0;
        read_data = 8'h5a;
        flush     = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_count", 32'(out_count), 32'd0);
        chk("reset_data",  out_data, 32'd0);
        chk("reset_pop",   32'(pop), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        empty = 1'b1;

        // Full word
        push_words(8'h11, 1); push_words(8'h22, 1); push_words(8'h33, 1); push_words(8'h44, 1);
        expect_word(32'h44332211, 3'd4);
        pop_cnt = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        chk("full_pops", 32'(pop_cnt), 32'd4);
        step(1'b0, 1'b1);
        chk("full_latency_valid", 32'(last_valid), 32'd1);
        drain(5);

        // Back-to-back words with no bubble
        push_words(8'h01, 8);
        expect_word(32'h04030201, 3'd4);
        expect_word(32'h08070605, 3'd4);
        pop_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1);
            chk("b2b_pop", 32'(last_pop), 32'd1);
        end
        drain(5);
        chk("b2b_pops", 32'(pop_cnt), 32'd8);

        // Backpressure
        push_words(8'h10, 8);
        expect_word(32'h13121110, 3'd4);
        expect_word(32'h17161514, 3'd4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            chk("bp_pop",   32'(last_pop), 32'd0);
            chk("bp_valid", 32'(last_valid), 32'd1);
            chk("bp_data",  last_data, 32'h13121110);
        end
        step(1'b0, 1'b1);
        chk("bp_release_pop", 32'(last_pop), 32'd1);
        drain(8);

        // Flush partial, including the word popped in the flush cycle
        push_words(8'haa, 1); push_words(8'hbb, 1);
        expect_word(32'h0000bbaa, 3'd2);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("flush_pop", 32'(last_pop), 32'd1);
        drain(4);

        // Flush with fill>0 and nothing to pop
        push_words(8'hcc, 1);
        expect_word(32'h000000cc, 3'd1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("flush_nopop", 32'(last_pop), 32'd0);
        drain(4);

        // Flush with fill=0 and empty FIFO: no output
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("flush_empty_valid", 32'(last_valid), 32'd0);

        // Empty handling
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            chk("empty_pop",   32'(last_pop), 32'd0);
            chk("empty_valid", 32'(last_valid), 32'd0);
        end

        // Asynchronous reset after two of four words
        push_words(8'h55, 4);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_data",  out_data, 32'd0);
        chk("rst_async_count", 32'(out_count), 32'd0);
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b1);
        chk("rst_pop", 32'(last_pop), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        push_words(8'h99, 2);
        expect_word(32'h9a995857, 3'd4);
        drain(10);

        chk("scoreboard_empty", 32'(exp_data_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_fifo_word_packer

`default_nettype wire

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of a show-ahead FIFO read port: watches empty and read_data, drives pop.
- Packs `ratio` consecutive FIFO words into one wide word.
- Presents the wide word on a valid/ready output interface.
- Sits between the flip-flop FIFOs in this directory and wider datapath sinks; a flush input forces out a partial word.

Parameters:
- width, 8, FIFO word width in bits
- ratio, 4, FIFO words per packed output word (>= 2)

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- empty  input  1  FIFO empty flag
- read_data  input  width  FIFO head word; valid whenever empty=0 (show-ahead)
- pop  output  1  pops FIFO head this cycle
- flush  input  1  request to emit the current partial word
- out_valid  output  1  packed word available
- out_ready  input  1  sink accepts packed word
- out_data  output  width*ratio  packed word; first popped word in bits [width-1:0]
- out_count  output  $clog2(ratio+1)  number of valid words in out_data (1..ratio)

Behaviour:
- Clock and reset: single clock clk; rst asynchronous, active-high.
  - During and after reset: state FILL, fill count 0, out_valid=0, out_count=0, out_data=0.
- Transfers: output transfer = out_valid & out_ready. pop is combinational: pop = ~empty & (state==FILL | out_ready).
  - Never pops when empty; one word per cycle maximum.
- FILL state: out_valid=0.
  - On pop: read_data is written to slot `fill` (bits [fill*width +: width]) and fill increments.
  - If the popped word is slot ratio-1: go to HOLD, out_count=ratio, fill=0.
  - flush with (fill>0 or pop): go to HOLD, out_count = fill + pop, fill=0. The word popped that cycle is included.
  - flush with fill=0 and no pop: ignored.
- HOLD state: out_valid=1; out_data and out_count are stable until transfer.
  - Transfer without pop: go to FILL.
  - Transfer with pop: the popped word goes into slot 0 of the next word; state FILL, fill=1. With ratio>=2 this never completes a word in the same cycle.
  - This gives sustained throughput of one FIFO word per cycle.
  - flush in HOLD is ignored. It is not latched; the requester must hold flush until it sees the intended partial output.
- Latency: a word popped in cycle N completes a packed word that is out_valid in cycle N+1.
- Output protocol: out_valid never deasserts without a transfer; standard valid/ready.
- Reset mid-operation: the partial word and any held output are discarded. No pop is asserted while rst is high.
- Width rules:
  - fill and out_count are $clog2(ratio+1) bits.
  - No arithmetic wraps; fill saturates by the state transition at ratio-1.

Optional Feature:
- Macro: FIFO_WORD_PACKER_ZERO_FILL_EN.
- Defined: on entry to HOLD with out_count<ratio, slots out_count..ratio-1 of out_data are forced to zero.
  - Slot storage is cleared on every transfer.
- Undefined: unused slots hold stale data from earlier words, and the bench must not check them.
  - Saves the clear logic.

Decomposition:
- Package fifo_word_packer_pkg:
  - state enum {FILL, HOLD}
  - function count_w(ratio) = $clog2(ratio+1)
- No sub-module is natural; the block is a single module. The existing FIFO (with fifo_monitor on its ports) is instantiated only in the bench, upstream of this block.

Test Plan (width=8, ratio=4):
- Full word: push 11,22,33,44 into the FIFO with out_ready=1.
  - Expect one transfer with out_data=0x44332211 and out_count=4.
  - pop high for exactly 4 cycles.
- Back-to-back words: 8 words 01..08 pushed continuously, out_ready=1.
  - Expect 0x04030201 then 0x08070605.
  - pop high for 8 consecutive cycles, no bubble at the HOLD->FILL boundary.
- Backpressure: out_ready=0 for 5 cycles after the first word completes, FIFO non-empty.
  - out_data stable and pop=0 throughout.
  - On the cycle out_ready rises, pop=1 and the next word lands in slot 0.
- Flush partial: push AA,BB, then flush=1 the cycle BB is popped.
  - Expect out_count=2, low half 0xBBAA.
  - Upper half 0x0000 with FIFO_WORD_PACKER_ZERO_FILL_EN defined.
  - Flush with fill=0 and FIFO empty produces no output.
- Empty handling: FIFO empty with out_ready=1 for 10 cycles.
  - pop=0 and out_valid=0.
  - fifo_monitor reports no pop-while-empty.
- Reset mid-operation: assert rst asynchronously after 2 of 4 words are popped.
  - Outputs go to 0 immediately.
  - After release, the next 4 words form a clean word with no stale slots.
